// File: rtl/bnn_img_writer.sv
// Frame writer: accepts DEPTH pixels per iSTART and emits registered buffer writes.
// Optional running checksum enabled by defining BNN_WR_CHKSUM_EN.
module bnn_img_writer #(
  parameter int DW    = 8,
  parameter int DEPTH = 20,
  parameter int AW    = 5
) (
  input  logic          iCLK,
  input  logic          iRST,
  input  logic          iCLR,
  input  logic          iSTART,
  input  logic          iHOLD,
  input  logic          iVALID,
  input  logic [DW-1:0] iDATA,
  output logic          oREADY,
  output logic [AW-1:0] oADDR,
  output logic [DW-1:0] oDATA,
  output logic          oWr_EN,
  output logic          oRd_EN,
  output logic          oBUSY,
  output logic          oDONE,
  output logic [7:0]    oCHKSUM
);

  typedef enum logic [1:0] {IDLE, WRITE, DONE_ST} state_t;

  state_t        state_q, state_d;
  logic [AW-1:0] cnt_q, cnt_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [DW-1:0] data_q, data_d;
  logic          wr_en_q, wr_en_d;
  logic          done_q, done_d;
  logic          ready;
  logic          accept;
  logic          last_beat;

  // Ready depends only on state and hold so upstream never sees a valid->ready loop.
  assign ready     = (state_q == WRITE) & ~iHOLD;
  assign accept    = iVALID & ready;
  assign last_beat = (cnt_q == AW'(DEPTH - 1));

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    data_d  = data_q;
    wr_en_d = 1'b0;
    done_d  = 1'b0;
    if (iCLR) begin
      state_d = IDLE;
      cnt_d   = '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (iSTART) state_d = WRITE;
        end
        WRITE: begin
          if (accept) begin
            wr_en_d = 1'b1;
            addr_d  = cnt_q;
            data_d  = iDATA;
            cnt_d   = cnt_q + AW'(1);
            if (last_beat) begin
              state_d = DONE_ST;
              done_d  = 1'b1;
            end
          end
        end
        DONE_ST: begin
          cnt_d   = '0;
          state_d = IDLE;
        end
        default: begin
          state_d = IDLE;
          cnt_d   = '0;
        end
      endcase
    end
  end

  always_ff @(posedge iCLK or posedge iRST) begin
    if (iRST) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      data_q  <= '0;
      wr_en_q <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      wr_en_q <= wr_en_d;
      done_q  <= done_d;
    end
  end

`ifdef BNN_WR_CHKSUM_EN
  logic [7:0] chk_q, chk_d;

  always_comb begin
    chk_d = chk_q;
    if (iCLR)
      chk_d = '0;
    else if (state_q == IDLE && iSTART)
      chk_d = '0;
    else if (state_q == WRITE && accept)
      chk_d = chk_q + 8'(iDATA);
  end

  always_ff @(posedge iCLK or posedge iRST) begin
    if (iRST) chk_q <= '0;
    else      chk_q <= chk_d;
  end

  assign oCHKSUM = chk_q;
`else
  assign oCHKSUM = '0;
`endif

  assign oREADY = ready;
  assign oADDR  = addr_q;
  assign oDATA  = data_q;
  assign oWr_EN = wr_en_q;
  assign oRd_EN = 1'b0;
  assign oBUSY  = (state_q != IDLE);
  assign oDONE  = done_q;

endmodule

// File: tb/tb_bnn_img_writer.sv
// Scoreboard bench for bnn_img_writer: a behavioural model queues expected writes
// at each accepting edge; a negedge monitor pops and compares them.
module tb_bnn_img_writer;
  localparam int DW = 8, DEPTH = 20, AW = 5;
`ifdef BNN_WR_CHKSUM_EN
  localparam int FRAME_SUM = 190;
`else
  localparam int FRAME_SUM = 0;
`endif

  logic          iCLK = 1'b0;
  logic          iRST = 1'b0;
  logic          iCLR = 1'b0;
  logic          iSTART = 1'b0;
  logic          iHOLD = 1'b0;
  logic          iVALID = 1'b0;
  logic [DW-1:0] iDATA = '0;
  logic          oREADY, oWr_EN, oRd_EN, oBUSY, oDONE;
  logic [AW-1:0] oADDR;
  logic [DW-1:0] oDATA;
  logic [7:0]    oCHKSUM;

  bnn_img_writer #(.DW(DW), .DEPTH(DEPTH), .AW(AW)) dut (
    .iCLK(iCLK), .iRST(iRST), .iCLR(iCLR), .iSTART(iSTART), .iHOLD(iHOLD),
    .iVALID(iVALID), .iDATA(iDATA), .oREADY(oREADY), .oADDR(oADDR),
    .oDATA(oDATA), .oWr_EN(oWr_EN), .oRd_EN(oRd_EN), .oBUSY(oBUSY),
    .oDONE(oDONE), .oCHKSUM(oCHKSUM)
  );

  always #5 iCLK = ~iCLK;

  int n_checks = 0;
  int n_pass   = 0;
  int wr_count = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
  endtask

  // Reference model
  typedef enum int {M_IDLE, M_WRITE, M_DONE} m_state_t;
  m_state_t m_state = M_IDLE;
  int       m_cnt = 0;
  int       m_chk = 0;
  logic     exp_wr = 1'b0;
  logic     exp_done = 1'b0;
  int       q_addr[$];
  int       q_data[$];

  always @(posedge iCLK or posedge iRST) begin
    if (iRST) begin
      m_state = M_IDLE; m_cnt = 0; m_chk = 0;
      exp_wr = 1'b0; exp_done = 1'b0;
      q_addr.delete(); q_data.delete();
    end else begin
      exp_wr = 1'b0; exp_done = 1'b0;
      if (iCLR) begin
        m_state = M_IDLE; m_cnt = 0; m_chk = 0;
      end else begin
        case (m_state)
          M_IDLE: if (iSTART) begin m_state = M_WRITE; m_chk = 0; end
          M_WRITE: if (iVALID && !iHOLD) begin
            q_addr.push_back(m_cnt);
            q_data.push_back(int'(iDATA));
            exp_wr = 1'b1;
            m_chk = (m_chk + int'(iDATA)) % 256;
            if (m_cnt == DEPTH - 1) begin m_state = M_DONE; exp_done = 1'b1; end
            m_cnt++;
          end
          M_DONE: begin m_cnt = 0; m_state = M_IDLE; end
          default: m_state = M_IDLE;
        endcase
      end
    end
  end

  function automatic int exp_chk();
`ifdef BNN_WR_CHKSUM_EN
    return m_chk;
`else
    return 0;
`endif
  endfunction

  always @(negedge iCLK) begin
    if (!iRST) begin
      check("wr_en", oWr_EN, exp_wr);
      check("done", oDONE, exp_done);
      check("busy", oBUSY, m_state != M_IDLE);
      check("ready", oREADY, (m_state == M_WRITE) && !iHOLD);
      check("rd_en", oRd_EN, 0);
      check("chksum", oCHKSUM, exp_chk());
      if (oWr_EN) wr_count++;
      if (exp_wr) begin
        if (q_addr.size() == 0) check("queue_empty", 1, 0);
        else begin
          check("addr", oADDR, q_addr.pop_front());
          check("data", oDATA, q_data.pop_front());
        end
      end
      if (oDONE) check("done_addr", oADDR, DEPTH - 1);
    end
  end

  task automatic tick();
    @(posedge iCLK); #1;
  endtask

  task automatic reset_zero_checks(input string pfx);
    check({pfx, "_addr"}, oADDR, 0);
    check({pfx, "_data"}, oDATA, 0);
    check({pfx, "_wr"}, oWr_EN, 0);
    check({pfx, "_done"}, oDONE, 0);
    check({pfx, "_busy"}, oBUSY, 0);
    check({pfx, "_ready"}, oREADY, 0);
    check({pfx, "_chk"}, oCHKSUM, 0);
  endtask

  // mode 0: stray iSTART + valid beyond frame, 1: hold at beat 8, 2: clear at beat 10, 3: reset at beat 6
  task automatic drive_frame(input int mode, input int dmul);
    int guard = 0;
    int hold_left = 3;
    iSTART = 1'b1; tick(); iSTART = 1'b0;
    while (m_state == M_WRITE && guard < 200) begin
      guard++;
      iVALID = 1'b1; iDATA = DW'(m_cnt * dmul); iHOLD = 1'b0; iSTART = 1'b0;
      if (mode == 0 && m_cnt == 5) iSTART = 1'b1;
      if (mode == 1 && m_cnt == 8 && hold_left > 0) begin iHOLD = 1'b1; hold_left--; end
      if (mode == 2 && m_cnt == 10) begin
        iCLR = 1'b1; tick(); iCLR = 1'b0;
        check("clr_wr", oWr_EN, 0);
        check("clr_busy", oBUSY, 0);
        break;
      end
      if (mode == 3 && m_cnt == 6) begin
        #2 iRST = 1'b1;
        #1 reset_zero_checks("rst_mid");
        #9 iRST = 1'b0;
        tick();
        break;
      end
      tick();
    end
    check("frame_bound", guard >= 200, 0);
    iSTART = 1'b0; iHOLD = 1'b0;
    if (mode == 0) repeat (3) tick();
    iVALID = 1'b0;
  endtask

  initial begin
    #2 iRST = 1'b1;
    #1 reset_zero_checks("rst_init");
    #19 iRST = 1'b0;
    tick();

    wr_count = 0;
    drive_frame(0, 1);
    check("frame_writes", wr_count, DEPTH);
    check("frame_chksum", oCHKSUM, FRAME_SUM);
    check("frame_idle", oBUSY, 0);

    drive_frame(1, 3);
    tick();

    drive_frame(2, 2);
    wr_count = 0;
    drive_frame(0, 1);
    check("after_clr_writes", wr_count, DEPTH);

    iCLR = 1'b1; iSTART = 1'b1; tick();
    iCLR = 1'b0; iSTART = 1'b0;
    check("clr_over_start", oBUSY, 0);
    tick();

    drive_frame(3, 1);
    wr_count = 0;
    iVALID = 1'b1; iDATA = 8'hA5;
    repeat (4) tick();
    iVALID = 1'b0;
    check("idle_valid_ignored", wr_count, 0);

    wr_count = 0;
    drive_frame(0, 1);
    check("post_rst_writes", wr_count, DEPTH);
    check("post_rst_chksum", oCHKSUM, FRAME_SUM);
    repeat (2) tick();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/bnn_img_writer.md
BNN_IMG_WRITER -- requirements
Module: bnn_img_writer

Interface
REQ-001 SHALL have parameter DW, default 8, pixel data width.
REQ-002 SHALL have parameter DEPTH, default 20, pixels per frame (buffer entries 0..DEPTH-1).
REQ-003 SHALL have parameter AW, default 5, address width; DEPTH <= 2^AW.
REQ-004 SHALL have port iCLK  input  1  single clock; all state updates on rising edge.
REQ-005 SHALL have port iRST  input  1  asynchronous, active-high reset.
REQ-006 SHALL have port iCLR  input  1  synchronous clear, active-high.
REQ-007 SHALL have port iSTART  input  1  begin a frame write; sampled in IDLE only.
REQ-008 SHALL have port iHOLD  input  1  reader-side back-pressure; forces oREADY low.
REQ-009 SHALL have port iVALID  input  1  upstream pixel valid.
REQ-010 SHALL have port iDATA  input  DW  upstream pixel.
REQ-011 SHALL have port oREADY  output  1  writer can accept a pixel this cycle.
REQ-012 SHALL have port oADDR  output  AW  buffer write address, registered.
REQ-013 SHALL have port oDATA  output  DW  buffer write data, registered.
REQ-014 SHALL have port oWr_EN  output  1  buffer write strobe, registered.
REQ-015 SHALL have port oRd_EN  output  1  tied 0; the writer never reads.
REQ-016 SHALL have port oBUSY  output  1  high when state != IDLE.
REQ-017 SHALL have port oDONE  output  1  one-cycle frame-complete pulse.
REQ-018 SHALL have port oCHKSUM  output  8  frame checksum (see Configuration).

Function
REQ-019 SHALL implement FSM states IDLE, WRITE, DONE_ST.
REQ-020 SHALL transition IDLE->WRITE on iSTART=1; iSTART SHALL be ignored in WRITE and DONE_ST.
REQ-021 SHALL drive oREADY = (state==WRITE) & ~iHOLD, combinationally from state and iHOLD only, never from iVALID.
REQ-022 SHALL accept a beat on an edge where iVALID & oREADY = 1; iVALID without oREADY SHALL have no effect.
REQ-023 SHALL, one cycle after acceptance of beat n (n = 0..DEPTH-1), present oWr_EN=1, oADDR=n, oDATA=that beat's iDATA; oWr_EN SHALL be 0 in every cycle that does not follow an acceptance.
REQ-024 SHALL keep an internal pixel counter that increments by 1 per accepted beat and holds otherwise.
REQ-025 SHALL transition WRITE->DONE_ST on acceptance of beat DEPTH-1, so that no beat DEPTH is ever accepted and oADDR never exceeds DEPTH-1.
REQ-026 SHALL assert oDONE=1 for exactly the one cycle spent in DONE_ST, coincident with the oWr_EN of the last beat; DONE_ST->IDLE SHALL follow unconditionally.
REQ-027 SHALL reset the pixel counter to 0 in DONE_ST, so the next frame starts at address 0.
REQ-028 SHALL, when iCLR=1, return to IDLE, zero the counter and checksum, and force oWr_EN=0 on the next cycle; a pending write is dropped.
REQ-029 SHALL give iCLR priority over iSTART and over beat acceptance when they occur in the same cycle.
REQ-030 SHALL, with iHOLD=1 mid-frame, stall with counter and address unchanged and resume at the next address when iHOLD falls.

Reset
REQ-031 SHALL, while iRST=1, force state=IDLE, counter=0, oADDR=0, oDATA=0, oWr_EN=0, oDONE=0, oBUSY=0, oREADY=0, oCHKSUM=0, asynchronously.
REQ-032 SHALL, on iRST asserted mid-frame, abandon the frame; after release the block SHALL wait in IDLE for iSTART.

Configuration
REQ-033 SHALL, when macro BNN_WR_CHKSUM_EN is defined, update oCHKSUM on each accepted beat to (oCHKSUM + low 8 bits of iDATA) mod 256, clear it on iSTART acceptance, and hold it from DONE_ST until the next iSTART, iCLR or iRST.
REQ-034 SHALL, when BNN_WR_CHKSUM_EN is undefined, tie oCHKSUM to 0 and contain no checksum logic.

Verification
REQ-035 Bench SHALL cover: iSTART, then iVALID continuously high with iDATA=0..19 -> oWr_EN on 20 consecutive cycles with oADDR=oDATA=0..19, oDONE with addr 19, then oBUSY=0.
REQ-036 Bench SHALL cover: iHOLD=1 for 3 cycles after beat 7 -> no oWr_EN during the stall, and the next write has oADDR=8.
REQ-037 Bench SHALL cover: iCLR at beat 10 -> oWr_EN=0 on the next cycle, state IDLE; a following frame starts at oADDR=0.
REQ-038 Bench SHALL cover: iRST pulse mid-frame -> all outputs 0 immediately (asynchronously); iVALID ignored until iSTART.
REQ-039 Bench SHALL cover, with BNN_WR_CHKSUM_EN defined: iDATA=0..19 -> oCHKSUM=190 after oDONE; undefined -> oCHKSUM=0 throughout.
REQ-040 Bench SHALL cover: iSTART pulsed during WRITE and iVALID high in DONE_ST/IDLE -> ignored, exactly 20 writes.
